// File: rtl/counter_pkg.sv
// Shared types for the up/down counter slice.
// Pure declarations; no timing or flow control of its own.
package counter_pkg;

   typedef enum logic {
      WRAP     = 1'b0,
      SATURATE = 1'b1
   } count_mode_t;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } count_dir_t;

endpackage : counter_pkg

// File: rtl/updown_counter_if.sv
// Control and status bundle of the up/down counter; master drives controls, slave is the counter.
// Status signals follow count with zero latency; there is no backpressure.
interface updown_counter_if #(
   parameter int WIDTH = 8
);
   import counter_pkg::*;

   logic             en;
   logic             dir;
   count_mode_t      mode;
   logic [WIDTH-1:0] limit;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             at_max;
   logic             at_zero;
   logic             wrapped;

   modport master (
      output en, dir, mode, limit, load, load_val,
      input  count, at_max, at_zero, wrapped
   );

   modport slave (
      input  en, dir, mode, limit, load, load_val,
      output count, at_max, at_zero, wrapped
   );

endinterface : updown_counter_if

// File: rtl/updown_prescaler.sv
// Divides en cycles: tick on the en cycle where the internal count equals prescale, then restarts.
// tick is combinational from registered state; clr or rst restart the period; no backpressure.
module updown_prescaler #(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] ps_cnt;
   logic                  hit;

   assign hit  = (ps_cnt == prescale);
   assign tick = en & hit;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ps_cnt <= '0;
      end else if (en) begin
         if (hit) begin
            ps_cnt <= '0;
         end else begin
            ps_cnt <= ps_cnt + PRESCALE_W'(1);
         end
      end
   end

endmodule : updown_prescaler

// File: rtl/updown_counter.sv
// Up/down counter over 0..limit with WRAP/SATURATE modes; optional prescaler via UPDOWN_COUNTER_PRESCALE_EN.
// count/wrapped update one clock after the step; at_max/at_zero are combinational; never stalls.
module updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef UPDOWN_COUNTER_PRESCALE_EN
   input  logic [PRESCALE_W-1:0] prescale,
`endif
   updown_counter_if.slave       bus
);

   if (WIDTH < 2 || PRESCALE_W < 1) begin : g_param_check
      $error("updown_counter: WIDTH must be >= 2 and PRESCALE_W >= 1");
   end

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_nxt;
   logic             wrapped_q;
   logic             wrapped_nxt;
   logic             step;
   logic             above_limit;
   logic             at_limit_or_above;
   logic             is_zero;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
   logic ps_tick;

   updown_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .clr      (bus.load),
      .prescale (prescale),
      .tick     (ps_tick)
   );

   assign step = ps_tick;
`else
   assign step = bus.en;
`endif

   assign above_limit       = (count_q > bus.limit);
   assign at_limit_or_above = (count_q >= bus.limit);
   assign is_zero           = (count_q == '0);

   // A loaded value above limit is kept until the next step pulls it back into range.
   always_comb begin
      count_nxt   = count_q;
      wrapped_nxt = 1'b0;
      if (bus.load) begin
         count_nxt = bus.load_val;
      end else if (step) begin
         if (count_dir_t'(bus.dir) == DIR_UP) begin
            if (!at_limit_or_above) begin
               count_nxt = count_q + WIDTH'(1);
            end else if (bus.mode == WRAP) begin
               count_nxt   = '0;
               wrapped_nxt = 1'b1;
            end else begin
               count_nxt = bus.limit;
            end
         end else begin
            if (above_limit) begin
               count_nxt = bus.limit;
            end else if (!is_zero) begin
               count_nxt = count_q - WIDTH'(1);
            end else if (bus.mode == WRAP) begin
               count_nxt   = bus.limit;
               wrapped_nxt = 1'b1;
            end else begin
               count_nxt = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         wrapped_q <= 1'b0;
      end else begin
         count_q   <= count_nxt;
         wrapped_q <= wrapped_nxt;
      end
   end

   assign bus.count   = count_q;
   assign bus.wrapped = wrapped_q;
   assign bus.at_max  = at_limit_or_above;
   assign bus.at_zero = is_zero;

endmodule : updown_counter
